// File: rtl/score_display_driver.sv
// Four-digit common-anode 7-segment scan driver.
// Digits 1:0 show the live score in decimal and digits 3:2 show the session high score.
// The high score is committed on each rising edge of GAME_OVER.
// All outputs are registered and update together, only on refresh ticks.
module score_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int PRESC_W     = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [3:0]   CURRENT_SCORE,
  input  logic         GAME_OVER,
  output logic [1:0]   STROBE_COUNTER,
  output logic [3:0]   SEG_SELECT,
  output logic [7:0]   HEX_OUT
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [3:0]         score_q;
  logic [3:0]         high_q;
  logic               go_q;
  logic               go_rise;
  logic [1:0]         idx_next;
  logic [3:0]         sel_next;
  logic [7:0]         hex_next;

  // Active-low segment pattern for a decimal digit, with the decimal point off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // Units digit of a 0..15 value; the tens digit is simply (v >= 10).
  function automatic logic [3:0] units_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  assign tick    = (presc == PRESC_LAST);
  assign go_rise = GAME_OVER & ~go_q;

  // Decode the digit that the next tick will select.
  always_comb begin
    idx_next = STROBE_COUNTER + 2'd1;
    sel_next = ~(4'b0001 << idx_next);
    hex_next = 8'hFF;
    case (idx_next)
      2'd0: hex_next = seg7(units_of(score_q));
      2'd1: hex_next = (score_q >= 4'd10) ? seg7(4'd1) : 8'hFF;
      2'd2: hex_next = seg7(units_of(high_q)) & 8'h7F;
      2'd3: hex_next = (high_q >= 4'd10) ? seg7(4'd1) : 8'hFF;
      default: hex_next = 8'hFF;
    endcase
  end

  // Refresh prescaler and registered scan outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc          <= '0;
      STROBE_COUNTER <= 2'd0;
      SEG_SELECT     <= 4'b1111;
      HEX_OUT        <= 8'hFF;
    end else begin
      if (tick) begin
        presc          <= '0;
        STROBE_COUNTER <= idx_next;
        SEG_SELECT     <= sel_next;
        HEX_OUT        <= hex_next;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Input sampling and high-score capture on the GAME_OVER rising edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      score_q <= 4'd0;
      high_q  <= 4'd0;
      go_q    <= 1'b0;
    end else begin
      score_q <= CURRENT_SCORE;
      go_q    <= GAME_OVER;
      if (go_rise && (CURRENT_SCORE > high_q)) begin
        high_q <= CURRENT_SCORE;
      end
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver with a short refresh divider.
module tb_score_display_driver;

  logic       CLK;
  logic       RESET;
  logic [3:0] CURRENT_SCORE;
  logic       GAME_OVER;
  logic [1:0] STROBE_COUNTER;
  logic [3:0] SEG_SELECT;
  logic [7:0] HEX_OUT;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  score_display_driver #(.REFRESH_DIV(4), .PRESC_W(2)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CURRENT_SCORE  (CURRENT_SCORE),
    .GAME_OVER      (GAME_OVER),
    .STROBE_COUNTER (STROBE_COUNTER),
    .SEG_SELECT     (SEG_SELECT),
    .HEX_OUT        (HEX_OUT)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edges since reset release; a tick edge leaves cyc at a nonzero multiple of 4.
  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] score;
    logic       go;
    logic [1:0] slot;
    logic [7:0] hex;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for a freshly loaded slot `want`, bounded so a stuck scan cannot hang.
  task automatic go_to_slot(input logic [1:0] want);
    int n;
    @(negedge CLK);
    n = 0;
    while (STROBE_COUNTER == want && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n = 0;
    while (STROBE_COUNTER != want && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (STROBE_COUNTER != want) begin
      checks++;
      errors++;
      $display("FAIL slot_timeout: got strobe %0d expected %0d", STROBE_COUNTER, want);
    end
  endtask

  task automatic chk_slot(input string name, input logic [1:0] slot, input logic [7:0] hex);
    logic [3:0] sel;
    sel = ~(4'b0001 << slot);
    go_to_slot(slot);
    chk(name, {4'h0, SEG_SELECT, HEX_OUT}, {4'h0, sel, hex});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  prev_strobe;
    logic [13:0] prev_out;
    logic        is_tick;
    int          onehot_bad;
    int          timing_bad;

    vecs[0]  = '{4'd13, 1'b0, 2'd0, 8'hB0};
    vecs[1]  = '{4'd13, 1'b0, 2'd1, 8'hF9};
    vecs[2]  = '{4'd9,  1'b0, 2'd0, 8'h90};
    vecs[3]  = '{4'd9,  1'b0, 2'd1, 8'hFF};
    vecs[4]  = '{4'd10, 1'b0, 2'd1, 8'hF9};
    vecs[5]  = '{4'd10, 1'b0, 2'd0, 8'hC0};
    vecs[6]  = '{4'd7,  1'b1, 2'd2, 8'h78};
    vecs[7]  = '{4'd7,  1'b0, 2'd3, 8'hFF};
    vecs[8]  = '{4'd12, 1'b1, 2'd2, 8'h24};
    vecs[9]  = '{4'd12, 1'b0, 2'd3, 8'hF9};
    vecs[10] = '{4'd5,  1'b1, 2'd2, 8'h24};
    vecs[11] = '{4'd5,  1'b0, 2'd3, 8'hF9};

    // Reset and first scan pass with score 0.
    RESET = 1'b1;
    CURRENT_SCORE = 4'd0;
    GAME_OVER = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_state", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd0, 4'b1111, 8'hFF});
    RESET = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      chk("blank_before_tick", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd0, 4'b1111, 8'hFF});
    end
    @(negedge CLK);
    chk("first_tick_d1", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd1, 4'b1101, 8'hFF});
    repeat (4) @(negedge CLK);
    chk("scan_d2", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd2, 4'b1011, 8'h40});
    repeat (4) @(negedge CLK);
    chk("scan_d3", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd3, 4'b0111, 8'hFF});
    repeat (4) @(negedge CLK);
    chk("scan_d0", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd0, 4'b1110, 8'hC0});

    // Live score and high-score vectors.
    for (int i = 0; i < 12; i++) begin
      CURRENT_SCORE = vecs[i].score;
      if (vecs[i].go) begin
        GAME_OVER = 1'b1;
        @(negedge CLK);
        GAME_OVER = 1'b0;
      end
      chk_slot($sformatf("vec%0d", i), vecs[i].slot, vecs[i].hex);
    end

    // GAME_OVER held high commits once; a lower score at the edge leaves high at 12.
    CURRENT_SCORE = 4'd5;
    GAME_OVER = 1'b1;
    @(negedge CLK);
    CURRENT_SCORE = 4'd8;
    @(negedge CLK);
    CURRENT_SCORE = 4'd15;
    repeat (3) @(negedge CLK);
    chk_slot("held_go_no_commit", 2'd2, 8'h24);
    GAME_OVER = 1'b0;
    @(negedge CLK);
    GAME_OVER = 1'b1;
    @(negedge CLK);
    GAME_OVER = 1'b0;
    chk_slot("repulse_d2", 2'd2, 8'h12);
    chk_slot("repulse_d3", 2'd3, 8'hF9);

    // Reset mid-scan while digit 2 is driven.
    go_to_slot(2'd2);
    RESET = 1'b1;
    @(negedge CLK);
    chk("reset_midscan", {2'b0, STROBE_COUNTER, SEG_SELECT, HEX_OUT}, {2'b0, 2'd0, 4'b1111, 8'hFF});
    RESET = 1'b0;
    chk_slot("high_cleared", 2'd2, 8'h40);

    // Reset coincident with a GAME_OVER rising edge.
    CURRENT_SCORE = 4'd9;
    @(negedge CLK);
    RESET = 1'b1;
    GAME_OVER = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    GAME_OVER = 1'b0;
    chk_slot("reset_beats_go", 2'd2, 8'h40);

    // Free-running scan: one anode low, outputs move only on tick edges.
    onehot_bad = 0;
    timing_bad = 0;
    prev_strobe = STROBE_COUNTER;
    prev_out = {2'b0, SEG_SELECT, HEX_OUT} | {STROBE_COUNTER, 12'h0};
    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0) CURRENT_SCORE = 4'($urandom_range(15));
      @(negedge CLK);
      is_tick = (cyc > 0) && (cyc % 4 == 0);
      if ($countones(~SEG_SELECT) != 1) onehot_bad++;
      if (!is_tick && ({STROBE_COUNTER, SEG_SELECT, HEX_OUT} != prev_out)) timing_bad++;
      if (is_tick && (STROBE_COUNTER != prev_strobe + 2'd1)) timing_bad++;
      prev_strobe = STROBE_COUNTER;
      prev_out = {STROBE_COUNTER, SEG_SELECT, HEX_OUT};
    end
    chk("onehot_anode", 16'(onehot_bad), 16'd0);
    chk("tick_only_changes", 16'(timing_bad), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
